// File: rtl/two_of_five_tx_if.sv
// Digit-in / serial-out bundle for the 2-of-5 transmitter.
// Names are from the transmitter's point of view: i_* flow in, o_* flow out.
interface two_of_five_tx_if;
  logic [3:0] i_digit;
  logic       i_digit_valid;
  logic       o_digit_ready;
  logic       o_ser_out;
  logic       o_ser_valid;
  logic       o_frame_start;
  logic [4:0] o_code_out;
  logic       o_digit_err;
  logic       o_chk_err;

  modport master (
    output i_digit, i_digit_valid,
    input  o_digit_ready, o_ser_out, o_ser_valid, o_frame_start,
           o_code_out, o_digit_err, o_chk_err
  );

  modport slave (
    input  i_digit, i_digit_valid,
    output o_digit_ready, o_ser_out, o_ser_valid, o_frame_start,
           o_code_out, o_digit_err, o_chk_err
  );
endinterface

// File: rtl/two_of_five_tx.sv
// BCD digit -> 2-of-5 code word, shifted out serially at BIT_PERIOD clocks per bit.
// Optional self-check is compiled in with macro TWO_OF_FIVE_TX_SELFCHECK_EN.
module two_of_five_tx #(
  parameter int BIT_PERIOD = 1,
  parameter bit MSB_FIRST  = 1'b1
) (
  input logic             i_clk,
  input logic             i_rst_n,
  two_of_five_tx_if.slave bus
);
  localparam int PW = $clog2(BIT_PERIOD + 1);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          r_state;
  logic [2:0]      r_bit_cnt;
  logic [PW-1:0]   r_per_cnt;
  logic [4:0]      r_code;
  logic            r_ser;
  logic            r_ser_vld;
  logic            r_fs;
  logic            r_err;
  logic            r_rdy;

  logic            w_accept;
  logic            w_legal;
  logic            w_bit_end;
  logic            w_last;
  logic            w_rdy_nxt;
  logic [4:0]      w_enc;

  function automatic logic [4:0] f_enc(input logic [3:0] d);
    case (d)
      4'd0:    return 5'b11000;
      4'd1:    return 5'b00011;
      4'd2:    return 5'b00101;
      4'd3:    return 5'b00110;
      4'd4:    return 5'b01001;
      4'd5:    return 5'b01010;
      4'd6:    return 5'b01100;
      4'd7:    return 5'b10001;
      4'd8:    return 5'b10010;
      4'd9:    return 5'b10100;
      default: return 5'b00000;
    endcase
  endfunction

  // idx is the position in transmit order, 0 = first bit on the line
  function automatic logic f_bit(input logic [4:0] c, input logic [2:0] idx);
    return MSB_FIRST ? c[3'd4 - idx] : c[idx];
  endfunction

  assign w_accept  = bus.i_digit_valid & r_rdy;
  assign w_legal   = (bus.i_digit <= 4'd9);
  assign w_enc     = f_enc(bus.i_digit);
  assign w_bit_end = (r_state == S_SHIFT) && (r_per_cnt == PW'(1));
  assign w_last    = w_bit_end && (r_bit_cnt == 3'd4);

  // READY is registered, so predict whether the next cycle is idle or bit 4's last cycle
  always_comb begin
    w_rdy_nxt = 1'b0;
    if (w_accept && w_legal)
      w_rdy_nxt = 1'b0;
    else if (r_state == S_IDLE || w_last)
      w_rdy_nxt = 1'b1;
    else if (w_bit_end)
      w_rdy_nxt = (r_bit_cnt == 3'd3) && (BIT_PERIOD == 1);
    else
      w_rdy_nxt = (r_bit_cnt == 3'd4) && (r_per_cnt == PW'(2));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_per_cnt <= '0;
      r_code    <= '0;
      r_ser     <= 1'b0;
      r_ser_vld <= 1'b0;
      r_fs      <= 1'b0;
      r_err     <= 1'b0;
      r_rdy     <= 1'b1;
    end else begin
      r_fs  <= 1'b0;
      r_err <= w_accept && !w_legal;
      r_rdy <= w_rdy_nxt;
      if (w_accept && w_legal) begin
        r_state   <= S_SHIFT;
        r_code    <= w_enc;
        r_bit_cnt <= '0;
        r_per_cnt <= PW'(BIT_PERIOD);
        r_ser     <= f_bit(w_enc, 3'd0);
        r_ser_vld <= 1'b1;
        r_fs      <= 1'b1;
      end else if (w_last) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= '0;
        r_per_cnt <= '0;
        r_ser     <= 1'b0;
        r_ser_vld <= 1'b0;
      end else if (w_bit_end) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        r_per_cnt <= PW'(BIT_PERIOD);
        r_ser     <= f_bit(r_code, r_bit_cnt + 3'd1);
      end else if (r_state == S_SHIFT) begin
        r_per_cnt <= r_per_cnt - PW'(1);
      end
    end
  end

  assign bus.o_digit_ready = r_rdy;
  assign bus.o_ser_out     = r_ser;
  assign bus.o_ser_valid   = r_ser_vld;
  assign bus.o_frame_start = r_fs;
  assign bus.o_code_out    = r_code;
  assign bus.o_digit_err   = r_err;

`ifdef TWO_OF_FIVE_TX_SELFCHECK_EN
  logic [2:0] r_ones;
  logic       r_chk;

  function automatic logic [2:0] f_pop(input logic [4:0] c);
    return {2'b0, c[0]} + {2'b0, c[1]} + {2'b0, c[2]} + {2'b0, c[3]} + {2'b0, c[4]};
  endfunction

  // r_ones tallies the bits as they are put on the line; judged on the frame's last cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ones <= '0;
      r_chk  <= 1'b0;
    end else begin
      if (w_last && r_ones != 3'd2)
        r_chk <= 1'b1;
      if (w_accept && w_legal) begin
        if (f_pop(w_enc) != 3'd2)
          r_chk <= 1'b1;
        r_ones <= {2'b0, f_bit(w_enc, 3'd0)};
      end else if (w_bit_end && !w_last) begin
        r_ones <= r_ones + {2'b0, f_bit(r_code, r_bit_cnt + 3'd1)};
      end
    end
  end

  assign bus.o_chk_err = r_chk;
`else
  assign bus.o_chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_two_of_five_tx.sv
// Directed bench for two_of_five_tx: a cycle table on a BIT_PERIOD=1/MSB-first instance,
// plus hand sequences for the stretched LSB-first frame, async reset and a full sweep.
module tb_two_of_five_tx;
  logic i_clk;
  logic i_rst_n;

  two_of_five_tx_if b1 ();
  two_of_five_tx_if b2 ();

  two_of_five_tx #(.BIT_PERIOD(1), .MSB_FIRST(1'b1)) u_dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b1)
  );
  two_of_five_tx #(.BIT_PERIOD(3), .MSB_FIRST(1'b0)) u_dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b2)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [3:0] d;
    logic       v;
    logic       rdy;
    logic       sv;
    logic       ser;
    logic       fs;
    logic       err;
    logic [4:0] code;
  } vec_t;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic add(input logic [3:0] d, input logic v, input logic rdy, input logic sv,
                     input logic ser, input logic fs, input logic err, input logic [4:0] code);
    vec_t t;
    t.d = d; t.v = v; t.rdy = rdy; t.sv = sv; t.ser = ser; t.fs = fs; t.err = err; t.code = code;
    vq.push_back(t);
  endtask

  function automatic logic [9:0] obs1();
    return {b1.o_digit_ready, b1.o_ser_valid, b1.o_ser_out, b1.o_frame_start,
            b1.o_digit_err, b1.o_code_out};
  endfunction

  logic [4:0] enc_tab [10];
  logic       sweep_bits [50];

  initial begin
    enc_tab = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

    // Each row: inputs driven this cycle, outputs expected in this same cycle.
    // Digit 0, single frame: 1,1,0,0,0
    add(0, 1, 1, 0, 0, 0, 0, 5'b00000);
    add(0, 0, 0, 1, 1, 1, 0, 5'b11000);
    add(0, 0, 0, 1, 1, 0, 0, 5'b11000);
    add(0, 0, 0, 1, 0, 0, 0, 5'b11000);
    add(0, 0, 0, 1, 0, 0, 0, 5'b11000);
    add(0, 0, 1, 1, 0, 0, 0, 5'b11000);
    add(0, 0, 1, 0, 0, 0, 0, 5'b11000);
    // 7 then 9 back-to-back with VALID held
    add(7, 1, 1, 0, 0, 0, 0, 5'b11000);
    add(9, 1, 0, 1, 1, 1, 0, 5'b10001);
    add(9, 1, 0, 1, 0, 0, 0, 5'b10001);
    add(9, 1, 0, 1, 0, 0, 0, 5'b10001);
    add(9, 1, 0, 1, 0, 0, 0, 5'b10001);
    add(9, 1, 1, 1, 1, 0, 0, 5'b10001);
    add(0, 0, 0, 1, 1, 1, 0, 5'b10100);
    add(0, 0, 0, 1, 0, 0, 0, 5'b10100);
    add(0, 0, 0, 1, 1, 0, 0, 5'b10100);
    add(0, 0, 0, 1, 0, 0, 0, 5'b10100);
    add(0, 0, 1, 1, 0, 0, 0, 5'b10100);
    add(0, 0, 1, 0, 0, 0, 0, 5'b10100);
    // Illegal 12 in idle
    add(12, 1, 1, 0, 0, 0, 0, 5'b10100);
    add(0, 0, 1, 0, 0, 0, 1, 5'b10100);
    add(0, 0, 1, 0, 0, 0, 0, 5'b10100);
    // Digit 3 (0,0,1,1,0); VALID while not ready ignored; illegal 15 on last cycle
    add(3, 1, 1, 0, 0, 0, 0, 5'b10100);
    add(0, 0, 0, 1, 0, 1, 0, 5'b00110);
    add(4, 1, 0, 1, 0, 0, 0, 5'b00110);
    add(0, 0, 0, 1, 1, 0, 0, 5'b00110);
    add(0, 0, 0, 1, 1, 0, 0, 5'b00110);
    add(15, 1, 1, 1, 0, 0, 0, 5'b00110);
    add(0, 0, 1, 0, 0, 0, 1, 5'b00110);
    add(0, 0, 1, 0, 0, 0, 0, 5'b00110);

    b1.i_digit = '0; b1.i_digit_valid = 1'b0;
    b2.i_digit = '0; b2.i_digit_valid = 1'b0;
    i_rst_n = 1'b0;

    @(negedge i_clk);
    chk("reset_dut1", 32'(obs1()), 32'({1'b1, 9'b0}));
    chk("reset_dut2", 32'({b2.o_digit_ready, b2.o_ser_valid, b2.o_ser_out, b2.o_frame_start,
                           b2.o_digit_err, b2.o_code_out}), 32'({1'b1, 9'b0}));
    chk("reset_chk1", 32'(b1.o_chk_err), 32'd0);
    i_rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      chk($sformatf("vec%0d", i), 32'(obs1()),
          32'({vq[i].rdy, vq[i].sv, vq[i].ser, vq[i].fs, vq[i].err, vq[i].code}));
      b1.i_digit = vq[i].d;
      b1.i_digit_valid = vq[i].v;
      @(negedge i_clk);
    end
    b1.i_digit_valid = 1'b0;

    // BIT_PERIOD=3, LSB first, digit 1 -> six ones then nine zeros
    chk("bp3_idle_rdy", 32'(b2.o_digit_ready), 32'd1);
    b2.i_digit = 4'd1; b2.i_digit_valid = 1'b1;
    @(negedge i_clk);
    b2.i_digit_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("bp3_ser%0d", i), 32'(b2.o_ser_out), 32'(i < 6));
      chk($sformatf("bp3_sv%0d", i), 32'(b2.o_ser_valid), 32'd1);
      chk($sformatf("bp3_fs%0d", i), 32'(b2.o_frame_start), 32'(i == 0));
      chk($sformatf("bp3_rdy%0d", i), 32'(b2.o_digit_ready), 32'(i == 14));
      @(negedge i_clk);
    end
    chk("bp3_end", 32'({b2.o_ser_valid, b2.o_digit_ready, b2.o_code_out}), 32'({2'b01, 5'b00011}));

    // Async reset in the middle of digit 5 (0,1,0,1,0)
    b1.i_digit = 4'd5; b1.i_digit_valid = 1'b1;
    @(negedge i_clk);
    b1.i_digit_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("rst_pre", 32'({b1.o_ser_valid, b1.o_code_out}), 32'({1'b1, 5'b01010}));
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(obs1()), 32'({1'b1, 9'b0}));
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      chk($sformatf("rst_after%0d", i), 32'(obs1()), 32'({1'b1, 9'b0}));
    end

    // Sweep 0..9 back-to-back; the line must carry every code without a gap
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 5; j++)
        sweep_bits[k*5 + j] = enc_tab[k][4-j];
    begin
      int nxt;
      nxt = 0;
      b1.i_digit = 4'd0; b1.i_digit_valid = 1'b1;
      @(negedge i_clk);
      for (int i = 0; i < 50; i++) begin
        chk($sformatf("sweep%0d", i), 32'({b1.o_ser_valid, b1.o_ser_out}),
            32'({1'b1, sweep_bits[i]}));
        if (b1.o_digit_ready) begin
          nxt++;
          if (nxt < 10) b1.i_digit = 4'(nxt);
          else b1.i_digit_valid = 1'b0;
        end
        @(negedge i_clk);
      end
      chk("sweep_done", 32'({b1.o_ser_valid, b1.o_code_out}), 32'({1'b0, 5'b10100}));
      chk("sweep_chk_err", 32'({b1.o_chk_err, b2.o_chk_err}), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
